// File: rtl/n_one_mux_rr.sv
// N:1 valid/ready multiplexer with a registered output beat.
// Channels are chosen either by a fixed select index or by round-robin arbitration among valid channels.
module n_one_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    output logic [W-1:0]  op,
    output logic [SW-1:0] op_ch,
    output logic          op_valid,
    input  logic          op_ready
);

    logic [W-1:0]  r_op;
    logic [SW-1:0] r_op_ch;
    logic          r_op_valid;
    logic [SW-1:0] r_rr_ptr;

    logic          w_load;
    logic          w_rr_found;
    logic [SW-1:0] w_rr_idx;
    logic [SW-1:0] w_cand;
    logic [SW-1:0] w_gnt;
    logic          w_gnt_ok;
    logic [N-1:0]  w_ready;
    logic          w_xfer_in;

    assign w_load = ~r_op_valid | op_ready;

    // Round-robin search: first valid channel after the last one granted, wrapping around.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = r_rr_ptr + SW'(k);
            if (!w_rr_found && in_valid[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Grant selection for the current cycle according to mode.
    always_comb begin
        w_gnt    = '0;
        w_gnt_ok = 1'b0;
        case (mode)
            1'b0: begin
                w_gnt    = sel;
                w_gnt_ok = 1'b1;
            end
            1'b1: begin
                w_gnt    = w_rr_idx;
                w_gnt_ok = w_rr_found;
            end
            default: begin
                w_gnt    = '0;
                w_gnt_ok = 1'b0;
            end
        endcase
    end

    // One-hot ready towards the granted producer, suppressed during reset.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_load && w_gnt_ok) begin
            w_ready[w_gnt] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    assign w_xfer_in = rst_n & w_load & w_gnt_ok & in_valid[w_gnt];

    // Output beat register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_op_ch    <= '0;
            r_op_valid <= 1'b0;
            r_rr_ptr   <= SW'(N - 1);
        end else if (w_xfer_in) begin
            r_op       <= in_data[int'(w_gnt)*W +: W];
            r_op_ch    <= w_gnt;
            r_op_valid <= 1'b1;
            if (mode) begin
                r_rr_ptr <= w_gnt;
            end
        end else if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
        end
    end

    assign in_ready = w_ready;
    assign op       = r_op;
    assign op_ch    = r_op_ch;
    assign op_valid = r_op_valid;

endmodule

// File: tb/tb_n_one_mux_rr.sv
// Self-checking bench for n_one_mux_rr: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_n_one_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   op;
    logic [SW-1:0]  op_ch;
    logic           op_valid;
    logic           op_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the beat held at the output and the last round-robin winner.
    bit m_valid;
    int m_data;
    int m_ch;
    int m_ptr;

    always #5 clk = ~clk;

    n_one_mux_rr #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .op_ch    (op_ch),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Valid channel with the smallest circular distance after the last winner, or -1.
    function automatic int rr_pick();
        int best  = -1;
        int bestd = N;
        for (int ch = 0; ch < N; ch++) begin
            int d;
            d = (ch - m_ptr - 1 + 2 * N) % N;
            if (in_valid[ch] && d < bestd) begin
                bestd = d;
                best  = ch;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_ch    = 0;
        m_ptr   = N - 1;
    endtask

    // One clock: check outputs and ready at the falling edge, then advance the model.
    task automatic cycle();
        int g;
        bit load;
        bit xin;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        chk("op_valid", op_valid, m_valid);
        chk("op", op, m_data);
        chk("op_ch", op_ch, m_ch);
        load = !m_valid || op_ready;
        if (mode) g = rr_pick();
        else      g = int'(sel);
        exp_rdy = '0;
        if (rst_n && load && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        xin = rst_n && load && (g >= 0) && in_valid[g];
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else if (xin) begin
            m_valid = 1'b1;
            m_data  = int'(in_data[g*W +: W]);
            m_ch    = g;
            if (mode) m_ptr = g;
        end else if (m_valid && op_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 1'b1;
        sel      = 2'd0;
        in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid = 4'b1111;
        op_ready = 1'b1;
        model_reset();

        // Reset held for two cycles with every producer valid.
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_op", op, 8'h00);
        chk("rst_in_ready", in_ready, 4'b0000);
        rst_n = 1'b1;
        cycle();
        chk("rr_first", op_ch, 2'd0);

        // Fixed select of channel 2, a new beat every cycle.
        mode = 1'b0;
        sel  = 2'd2;
        cycle();
        chk("fix_op", op, 8'h33);
        chk("fix_ch", op_ch, 2'd2);
        cycle();
        chk("fix_valid", op_valid, 1'b1);

        // Round-robin fairness, all channels valid.
        reset_seq();
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_seq", op_ch, i % N);
        end

        // Round-robin with only channels 1 and 3 valid.
        reset_seq();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_1010", op_ch, (i % 2 == 0) ? 2'd1 : 2'd3);
        end

        // Back-pressure holding 0x22 from channel 1.
        reset_seq();
        in_valid = 4'b1111;
        cycle();
        cycle();
        chk("bp_load", op, 8'h22);
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_op", op, 8'h22);
            chk("bp_valid", op_valid, 1'b1);
            chk("bp_rdy", in_ready, 4'b0000);
        end
        op_ready = 1'b1;
        cycle();
        chk("bp_next_ch", op_ch, 2'd2);
        chk("bp_next_op", op, 8'h33);

        // Mode switch keeps the round-robin pointer.
        reset_seq();
        cycle();
        cycle();
        chk("ms_ch1", op_ch, 2'd1);
        mode = 1'b0;
        sel  = 2'd3;
        cycle();
        cycle();
        chk("ms_fix", op_ch, 2'd3);
        mode = 1'b1;
        cycle();
        chk("ms_resume", op_ch, 2'd2);

        // Reset while a beat is pending.
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_valid", op_valid, 1'b0);
        rst_n = 1'b1;
        cycle();
        chk("mid_rst_ptr", op_ch, 2'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            mode     = 1'($urandom_range(0, 1));
            sel      = 2'($urandom_range(0, N - 1));
            in_valid = 4'($urandom);
            in_data  = 32'($urandom);
            op_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/n_one_mux_rr.md
Name: n_one_mux_rr

Overview:
- Parametrised N:1 data multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Successor to the combinational 2:1 mux: generalised in channel count and data width.
- Adds a second selection mode, round-robin arbitration across valid channels, alongside fixed-select.
- Sits between several producer blocks and a single consumer; provides one cycle of latency and full back-pressure.

Parameters:
- N, 4, number of input channels; power of two, 2..16.
- W, 8, data width per channel in bits.
- SW, log2(N), select/channel-index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SW  channel index used when mode = 0.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- op  output  W  registered output data.
- op_ch  output  SW  registered index of the channel that produced op.
- op_valid  output  1  output valid.
- op_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n = 0 at a clk edge): op = 0, op_ch = 0, op_valid = 0, rr_ptr = N-1 (so channel 0 has first priority). in_ready = 0 while rst_n = 0.
- Load enable: load = ~op_valid | op_ready. The output register accepts a new beat whenever it is empty or is being drained in the same cycle. This gives full throughput of one beat per cycle.
- Grant, mode 0: g = sel. in_ready[g] = load; all other in_ready bits = 0.
- Grant, mode 1: g = first index with in_valid set, searching circularly from rr_ptr+1 through rr_ptr (wrap modulo N). in_ready[g] = load; all other bits = 0. If no in_valid bit is set, there is no grant and all in_ready bits = 0.
- Transfer in: occurs when load & in_valid[g] & in_ready[g]. On the next edge: op <= in_data[g], op_ch <= g, op_valid <= 1. In mode 1 only, rr_ptr <= g.
- Transfer out: occurs when op_valid & op_ready. If no transfer in happens in the same cycle, op_valid <= 0 on the next edge. op and op_ch hold their last values.
- Stall: op_valid = 1 and op_ready = 0 gives load = 0 and all in_ready = 0. op, op_ch and op_valid hold. Producers must hold their data.
- Latency: 1 cycle from an input transfer to op_valid.
- Simultaneous in/out in one cycle: the output is replaced with no bubble; op_valid stays 1.
- rr_ptr updates only on a mode-1 transfer. It is retained while mode = 0 and resumes from that value when mode returns to 1.
- mode and sel may change on any cycle. They affect only the grant of that cycle and never alter a beat already held in the output register.
- Reset asserted mid-stream: the pending output beat is discarded (op_valid = 0); no input is consumed in that cycle.
- Data is passed through unmodified: no width conversion, no arithmetic.

Test Plan:
- Reset: N=4, W=8; hold rst_n = 0 for 2 cycles with all in_valid = 1 -> in_ready = 0000, op_valid = 0, op = 0x00, op_ch = 0. First mode-1 grant after reset is channel 0.
- Fixed select: mode = 0, sel = 2, in_data = {0x44,0x33,0x22,0x11}, in_valid = 1111, op_ready = 1 -> in_ready = 0100. One cycle later op = 0x33, op_ch = 2, op_valid = 1. A new beat arrives every cycle.
- Round-robin fairness: mode = 1, in_valid = 1111 constant, op_ready = 1 -> op_ch sequence 0,1,2,3,0,1 on consecutive cycles. With in_valid = 1010 -> sequence 1,3,1,3.
- Back-pressure: output holds 0x22 from channel 1, op_ready = 0 for 3 cycles -> op stays 0x22, op_valid = 1, in_ready = 0000. When op_ready = 1, the next beat arrives from channel 2 with no bubble.
- Mode switch: run mode 1 until channel 1 is granted, switch to mode 0 with sel = 3 for 2 transfers, then return to mode 1 -> next round-robin grant is channel 2 (all valid).
- Reset mid-stream: op_valid = 1 and rst_n = 0 for one cycle -> op_valid = 0 and rr_ptr = 3 on the next cycle. No input transfer is recorded during that cycle.
